// File: rtl/alu_operand_fifo_if.sv
// alu_operand_fifo_if: operand push/pop handshake bundle; slave = FIFO (takes in_*, out_ready; drives in_ready, out_*, count), master = producer/consumer side
interface alu_operand_fifo_if #(parameter int DEPTH = 4);
  logic                       in_valid;
  logic                       in_ready;
  logic [3:0]                 in_op;
  logic [3:0]                 in_a;
  logic [3:0]                 in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [3:0]                 out_op;
  logic [3:0]                 out_a;
  logic [3:0]                 out_b;
  logic [$clog2(DEPTH):0]     count;
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, count
  );
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, count
  );
endinterface

// File: rtl/alu_operand_fifo.sv
// alu_operand_fifo: DEPTH-entry {op,a,b} FIFO feeding ALU units; ports clk, rst_n (sync active-low), flush, s (slave bundle: in_* push side, out_* pop side, count)
module alu_operand_fifo #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_operand_fifo_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [11:0]   mem_q [DEPTH];
  logic [11:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  always_comb begin
    s.in_ready  = cnt_q < CW'(DEPTH);
    s.out_valid = cnt_q != '0;
    {s.out_op, s.out_a, s.out_b} = s.out_valid ? mem_q[rd_q] : 12'h0;
    s.count = cnt_q;
    push = s.in_valid && s.in_ready;
    pop  = s.out_valid && s.out_ready;
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = {s.in_op, s.in_a, s.in_b};
    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_fifo.sv
// tb_alu_operand_fifo: directed stimulus with a scoreboard queue checked by a negedge monitor
module tb_alu_operand_fifo;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   mc = 0;
  logic [11:0] q[$];
  always #5 clk = ~clk;
  alu_operand_fifo_if #(.DEPTH(D)) bus();
  alu_operand_fifo #(.DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .s(bus.slave));
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic cyc(input logic fl, input logic rn, input logic iv, input logic [3:0] op,
                     input logic [3:0] a, input logic [3:0] b, input logic ordy);
    logic acc, pp;
    flush = fl;
    rst_n = rn;
    bus.in_valid = iv;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.out_ready = ordy;
    acc = rn && !fl && iv && (mc < D);
    pp  = rn && !fl && ordy && (mc > 0);
    if (acc) q.push_back({op, a, b});
    mc = (!rn || fl) ? 0 : mc + int'(acc) - int'(pp);
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
  endtask
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n || flush) q.delete();
    else if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_op", int'(bus.out_op), int'(e[11:8]));
        chk("sb_a", int'(bus.out_a), int'(e[7:4]));
        chk("sb_b", int'(bus.out_b), int'(e[3:0]));
      end
    end
    if (!bus.out_valid) chk("idle_zero", int'({bus.out_op, bus.out_a, bus.out_b}), 0);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_op = 4'h0;
    bus.in_a = 4'h0;
    bus.in_b = 4'h0;
    bus.out_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 4'h2, 4'h2, 4'h2, 1'b0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_op", int'(bus.out_op), 0);
    cyc(1'b0, 1'b1, 1'b1, 4'h3, 4'h5, 4'hA, 1'b0);
    chk("first_out_valid", int'(bus.out_valid), 1);
    chk("first_out_op", int'(bus.out_op), 3);
    chk("first_out_a", int'(bus.out_a), 5);
    chk("first_out_b", int'(bus.out_b), 10);
    chk("first_count", int'(bus.count), 1);
    drain();
    chk("first_drained", int'(bus.count), 0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i), 4'(i + 4), 4'(i + 8), 1'b0);
    chk("full_count", int'(bus.count), 4);
    chk("full_in_ready", int'(bus.in_ready), 0);
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    chk("fifth_rejected", int'(bus.count), 4);
    chk("full_in_ready2", int'(bus.in_ready), 0);
    chk("hold_head_op", int'(bus.out_op), 1);
    chk("hold_head_a", int'(bus.out_a), 5);
    repeat (4) drain();
    chk("full_drained", int'(bus.count), 0);
    chk("full_drained_valid", int'(bus.out_valid), 0);
    cyc(1'b0, 1'b1, 1'b1, 4'h2, 4'h3, 4'h4, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 4'h5, 4'h6, 4'h7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'(i), 4'(15 - i), 4'(i * 3), 1'b1);
      chk("steady_count", int'(bus.count), 2);
    end
    repeat (2) drain();
    chk("steady_drained", int'(bus.count), 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i + 8), 4'(i), 4'(i + 1), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 4'hC, 4'hD, 4'hE, 1'b1);
    chk("fullpop_count", int'(bus.count), 3);
    chk("fullpop_in_ready", int'(bus.in_ready), 1);
    cyc(1'b0, 1'b1, 1'b1, 4'hC, 4'hD, 4'hE, 1'b0);
    chk("pending_accepted", int'(bus.count), 4);
    repeat (4) drain();
    chk("fullpop_drained", int'(bus.count), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i + 1), 4'(i + 2), 4'(i + 3), 1'b0);
    chk("preflush_count", int'(bus.count), 3);
    cyc(1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 4'h3, 1'b1);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_out_valid", int'(bus.out_valid), 0);
    chk("flush_outputs", int'({bus.out_op, bus.out_a, bus.out_b}), 0);
    chk("flush_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i + 4), 4'(i + 5), 4'(i + 6), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_outputs", int'({bus.out_op, bus.out_a, bus.out_b}), 0);
    cyc(1'b0, 1'b1, 1'b1, 4'h7, 4'h8, 4'h9, 1'b0);
    chk("postrst_op", int'(bus.out_op), 7);
    chk("postrst_a", int'(bus.out_a), 8);
    chk("postrst_b", int'(bus.out_b), 9);
    chk("postrst_count", int'(bus.count), 1);
    drain();
    chk("postrst_drained", int'(bus.count), 0);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
